// File: rtl/mem_pkg.sv
// Shared widths and load-op encoding for the MEM stage.
// Sub-word loads are enabled by defining MEM_SUBWORD_LOAD_EN.
package mem_pkg;
  localparam int RF_BUS_W = 38;
  localparam int LD_OP_W  = 5;

  localparam int LD_B  = 0;
  localparam int LD_BU = 1;
  localparam int LD_H  = 2;
  localparam int LD_HU = 3;
  localparam int LD_W  = 4;

  typedef struct packed {
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] result;
  } rf_bus_t;
endpackage

// File: rtl/mem_load_align.sv
// Load data alignment and extension for the MEM stage.
// Sub-word select is present only when MEM_SUBWORD_LOAD_EN is defined.
module mem_load_align
  import mem_pkg::*;
(
  input  logic [31:0]        word,
  input  logic [1:0]         a,
  input  logic [LD_OP_W-1:0] ld_op,
  output logic [31:0]        value
);

`ifdef MEM_SUBWORD_LOAD_EN
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[7:0];
    unique case (a)
      2'd0: byte_v = word[7:0];
      2'd1: byte_v = word[15:8];
      2'd2: byte_v = word[23:16];
      2'd3: byte_v = word[31:24];
      default: byte_v = word[7:0];
    endcase
  end

  assign half_v = a[1] ? word[31:16] : word[15:0];

  always_comb begin
    value = word;
    unique case (1'b1)
      ld_op[LD_B]:  value = {{24{byte_v[7]}}, byte_v};
      ld_op[LD_BU]: value = {24'd0, byte_v};
      ld_op[LD_H]:  value = {{16{half_v[15]}}, half_v};
      ld_op[LD_HU]: value = {16'd0, half_v};
      ld_op[LD_W]:  value = word;
      default:      value = word;
    endcase
  end
`else
  logic unused_align;

  assign unused_align = ^{a, ld_op};
  assign value = word;
`endif

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: payload regs, load completion, WB back-pressure hold.
// Optional sub-word loads via MEM_SUBWORD_LOAD_EN (see mem_load_align).
module mem_stage
  import mem_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                ex_to_mem_valid,
  output logic                mem_allowin,
  input  logic [31:0]         ex_pc,
  input  logic [RF_BUS_W-1:0] ex_rf_all,
  input  logic [LD_OP_W-1:0]  ex_ld_op,
  input  logic [31:0]         data_sram_rdata,
  input  logic                wb_allowin,
  output logic                mem_valid,
  output logic                mem_to_wb_valid,
  output logic [31:0]         mem_pc,
  output logic [RF_BUS_W-1:0] mem_rf_all,
  output logic [RF_BUS_W-1:0] mem_fwd_all
);

  logic               ready_go;
  rf_bus_t            ex_bus;
  rf_bus_t            bus_q;
  logic [LD_OP_W-1:0] ld_op_q;
  logic               held;
  logic [31:0]        rdata_buf;
  logic [31:0]        word;
  logic [31:0]        ld_value;
  logic [31:0]        final_wdata;

  assign ready_go        = 1'b1;
  assign mem_allowin     = ~mem_valid | (ready_go & wb_allowin);
  assign mem_to_wb_valid = mem_valid & ready_go;
  assign ex_bus          = rf_bus_t'(ex_rf_all);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
    end else if (mem_allowin) begin
      mem_valid <= ex_to_mem_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_pc  <= 32'd0;
      bus_q   <= '0;
      ld_op_q <= '0;
    end else if (ex_to_mem_valid && mem_allowin) begin
      mem_pc  <= ex_pc;
      bus_q   <= ex_bus;
      ld_op_q <= ex_ld_op;
    end
  end

  // SRAM data is only valid in the first MEM cycle; keep it while WB stalls.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      held      <= 1'b0;
      rdata_buf <= 32'd0;
    end else if (mem_allowin) begin
      held      <= 1'b0;
    end else if (mem_valid && !wb_allowin && !held) begin
      held      <= 1'b1;
      rdata_buf <= data_sram_rdata;
    end
  end

  assign word = held ? rdata_buf : data_sram_rdata;

  mem_load_align u_align (
    .word  (word),
    .a     (bus_q.result[1:0]),
    .ld_op (ld_op_q),
    .value (ld_value)
  );

  assign final_wdata = (|ld_op_q) ? ld_value : bus_q.result;

  assign mem_rf_all  = {bus_q.rf_we, bus_q.rf_waddr, final_wdata};
  assign mem_fwd_all = {mem_valid & bus_q.rf_we,
                        bus_q.rf_waddr, final_wdata};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the EX stage and the WB stage. Registers the EX payload and completes loads against the synchronous data SRAM's read data, including byte/halfword select and extension. Holds the returned word across WB back-pressure. Drives the 38-bit register-write bundle and PC to WB, plus a forwarding bundle to ID.

## Interface
Parameters:
- none; bus widths come from the shared package.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; synchronous, active-low
- ex_to_mem_valid  in  1  EX holds a valid instruction for MEM
- mem_allowin  out  1  MEM accepts a new instruction this cycle
- ex_pc  in  32  PC of the EX instruction
- ex_rf_all  in  38  {rf_we, rf_waddr[4:0], alu_result[31:0]}; for loads, alu_result is the byte address
- ex_ld_op  in  5  one-hot {ld_w, ld_hu, ld_h, ld_bu, ld_b}; all-zero means non-load
- data_sram_rdata  in  32  SRAM read data, valid only in the first cycle the load occupies MEM
- wb_allowin  in  1  WB accepts this cycle
- mem_valid  out  1  MEM holds a valid instruction
- mem_to_wb_valid  out  1  mem_valid & ready_go
- mem_pc  out  32  registered PC
- mem_rf_all  out  38  {rf_we, rf_waddr, final_wdata}
- mem_fwd_all  out  38  {mem_valid & rf_we, rf_waddr, final_wdata} to ID bypass

## Operation
- Handshake:
  - ready_go = 1.
  - mem_allowin = ~mem_valid | (ready_go & wb_allowin).
  - On mem_allowin: mem_valid <= ex_to_mem_valid.
- Payload registers (pc, rf_we, rf_waddr, result, ld_op) load only when ex_to_mem_valid & mem_allowin. Otherwise they hold.
- Read-data hold:
  - Flag held (1 bit) and register rdata_buf (32 bits).
  - If mem_valid & ~wb_allowin & ~held: rdata_buf <= data_sram_rdata and held <= 1.
  - held clears whenever mem_allowin = 1.
  - Effective word = held ? rdata_buf : data_sram_rdata.
- Load alignment, with a = result[1:0]:
  - ld_b / ld_bu: byte = word[8a+7:8a], sign- or zero-extended respectively.
  - ld_h / ld_hu: half = a[1] ? word[31:16] : word[15:0], sign- or zero-extended; a[0] ignored.
  - ld_w: the full word; a ignored.
  - No misalignment detection.
- final_wdata = (ld_op != 0) ? aligned load value : result.
- rf_we and rf_waddr pass through unchanged. Gating by valid is done only on mem_fwd_all; WB gates its own copy.

## Timing
- Reset values: mem_valid=0, held=0, all payload registers 0, rdata_buf=0. Consequently mem_to_wb_valid=0, mem_pc=0, mem_rf_all=0, mem_fwd_all=0.
- Latency: 1 cycle per stage. An instruction accepted at edge N is presented to WB during cycle N+1 and transfers at the first edge where wb_allowin=1.
- SRAM: the address is issued from EX, and data appears in the first MEM cycle. final_wdata for a load is combinational from data_sram_rdata in that cycle.
- Back-pressure: while wb_allowin=0, all outputs are stable across cycles, including load data once captured.
- Simultaneous transfer: an instruction leaves and a new one enters on the same edge; held clears on that edge.
- Bubble: when ex_to_mem_valid=0 and mem_allowin=1, mem_valid drops and the payload holds stale data, which is masked by valid.
- Reset mid-stall clears valid and held regardless of wb_allowin.

## Configuration
- MEM_SUBWORD_LOAD_EN:
  - Defined: full byte/halfword alignment and extension as above.
  - Undefined: the alignment logic is omitted, and any nonzero ex_ld_op returns the full effective word.

## Structure
- Shared package mem_pkg:
  - RF_BUS_W=38 and LD_OP_W=5.
  - Indices LD_B=0, LD_BU=1, LD_H=2, LD_HU=3, LD_W=4.
- Sub-module mem_load_align: combinational; inputs (word, a, ld_op), output the 32-bit value; body under MEM_SUBWORD_LOAD_EN.
- Handshake, payload and hold registers stay in mem_stage.

## Test plan
- Non-load: result=0x1234_5678, rf_we=1, waddr=5, wb_allowin=1 -> next cycle mem_rf_all={1,5,0x12345678}, mem_fwd_all identical, mem_to_wb_valid=1.
- Load sign extension: ld_b at addr 0x...03 with rdata=0x80FF_0011 -> wdata=0xFFFF_FF80; ld_bu at addr 0x...03 -> 0x0000_0080; ld_h at addr 0x...02 -> 0xFFFF_80FF; ld_hu at addr 0x...00 -> 0x0000_0011.
- Stall hold: ld_w with rdata=0xDEAD_BEEF, wb_allowin=0 for 3 cycles while rdata changes to 0 -> wdata stays 0xDEADBEEF, mem_allowin=0, transfer on release.
- Back-to-back loads with wb_allowin=1 every cycle -> one transfer per cycle, held never set, each wdata taken from its own first-cycle rdata.
- Reset asserted during a stall with held=1 -> next cycle mem_valid=0, mem_fwd_all[37]=0, held=0.
- Macro undefined: ld_b at addr 0x...01 with rdata=0x1122_3344 -> wdata=0x11223344.
